// File: rtl/atm_account_server.sv
// Bank-side account server: account table with PIN/balance/lockout state,
// serving one verify/balance/deposit/withdraw/transfer/PIN-change at a time.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready + req_op, req_account, req_pin, req_new_pin,
//     req_dest_account, req_amount : request handshake and fields
//   rsp_valid/rsp_ready + rsp_status, rsp_balance : response handshake
module atm_account_server #(
  parameter int          NUM_ACCOUNTS  = 4,
  parameter logic [16:0] BASE_ACCOUNT  = 17'd1000,
  parameter logic [16:0] DEFAULT_PIN   = 17'd1234,
  parameter logic [18:0] INIT_BALANCE  = 19'd5000,
  parameter int          MAX_PIN_TRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [16:0] req_account,
  input  logic [16:0] req_pin,
  input  logic [16:0] req_new_pin,
  input  logic [16:0] req_dest_account,
  input  logic [18:0] req_amount,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [18:0] rsp_balance
);

  localparam int IW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int FW = $clog2(MAX_PIN_TRIES + 1);

  localparam logic [2:0] OP_DEP = 3'd2;
  localparam logic [2:0] OP_WDR = 3'd3;
  localparam logic [2:0] OP_XFR = 3'd4;
  localparam logic [2:0] OP_PIN = 3'd5;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_BAD_PIN = 3'd1;
  localparam logic [2:0] ST_NO_ACCT = 3'd2;
  localparam logic [2:0] ST_INSUFF  = 3'd3;
  localparam logic [2:0] ST_OVF     = 3'd4;
  localparam logic [2:0] ST_LOCKED  = 3'd5;
  localparam logic [2:0] ST_BAD_OP  = 3'd6;
  localparam logic [2:0] ST_NO_DEST = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_EXEC, S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [2:0]  r_op_q;
  logic [16:0] r_acct_q, r_pin_q, r_npin_q, r_dst_q;
  logic [18:0] r_amt_q;

  logic [16:0] tab_pin_q  [NUM_ACCOUNTS];
  logic [18:0] tab_bal_q  [NUM_ACCOUNTS];
  logic [FW-1:0] tab_fail_q [NUM_ACCOUNTS];
  logic        tab_lock_q [NUM_ACCOUNTS];

  logic          src_hit_q, src_hit_d, dst_hit_q, dst_hit_d;
  logic [IW-1:0] src_idx_q, src_idx_d, dst_idx_q, dst_idx_d;

  logic [2:0]  rsp_status_q;
  logic [18:0] rsp_balance_q;

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_status  = rsp_status_q;
  assign rsp_balance = rsp_balance_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Account numbers are implicit: entry i answers to BASE_ACCOUNT+i.
  always_comb begin
    src_hit_d = 1'b0;
    src_idx_d = '0;
    dst_hit_d = 1'b0;
    dst_idx_d = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (r_acct_q == BASE_ACCOUNT + 17'(i)) begin
        src_hit_d = 1'b1;
        src_idx_d = IW'(i);
      end
      if (r_dst_q == BASE_ACCOUNT + 17'(i)) begin
        dst_hit_d = 1'b1;
        dst_idx_d = IW'(i);
      end
    end
  end

  logic [18:0]   src_bal, dst_bal;
  logic [19:0]   dep_sum, xfr_sum;
  logic [FW-1:0] fail_nx;
  logic [2:0]    ex_status;
  logic [18:0]   ex_bal;
  logic          src_we, dst_we, pin_we;
  logic          fail_inc, fail_clr, lock_set;
  logic [18:0]   src_nx, dst_nx;

  assign src_bal = tab_bal_q[src_idx_q];
  assign dst_bal = tab_bal_q[dst_idx_q];
  assign dep_sum = {1'b0, src_bal} + {1'b0, r_amt_q};
  assign xfr_sum = {1'b0, dst_bal} + {1'b0, r_amt_q};
  assign fail_nx = tab_fail_q[src_idx_q] + FW'(1);

  // Checks are ordered; the first failing one decides the status.
  always_comb begin
    ex_status = ST_OK;
    ex_bal    = '0;
    src_we    = 1'b0;
    src_nx    = src_bal;
    dst_we    = 1'b0;
    dst_nx    = dst_bal;
    pin_we    = 1'b0;
    fail_inc  = 1'b0;
    fail_clr  = 1'b0;
    lock_set  = 1'b0;
    if (r_op_q[2:1] == 2'b11) begin
      ex_status = ST_BAD_OP;
    end else if (!src_hit_q) begin
      ex_status = ST_NO_ACCT;
    end else if (tab_lock_q[src_idx_q]) begin
      ex_status = ST_LOCKED;
    end else if (r_pin_q != tab_pin_q[src_idx_q]) begin
      ex_status = ST_BAD_PIN;
      fail_inc  = 1'b1;
      lock_set  = (fail_nx >= FW'(MAX_PIN_TRIES));
    end else begin
      fail_clr = 1'b1;
      ex_bal   = src_bal;
      unique case (r_op_q)
        OP_DEP: begin
          if (dep_sum[19]) begin
            ex_status = ST_OVF;
          end else begin
            src_we = 1'b1;
            src_nx = dep_sum[18:0];
            ex_bal = dep_sum[18:0];
          end
        end
        OP_WDR: begin
          if (r_amt_q > src_bal) begin
            ex_status = ST_INSUFF;
          end else begin
            src_we = 1'b1;
            src_nx = src_bal - r_amt_q;
            ex_bal = src_bal - r_amt_q;
          end
        end
        OP_XFR: begin
          if (!dst_hit_q || dst_idx_q == src_idx_q) begin
            ex_status = ST_NO_DEST;
          end else if (r_amt_q > src_bal) begin
            ex_status = ST_INSUFF;
          end else if (xfr_sum[19]) begin
            ex_status = ST_OVF;
          end else begin
            src_we = 1'b1;
            src_nx = src_bal - r_amt_q;
            dst_we = 1'b1;
            dst_nx = xfr_sum[18:0];
            ex_bal = src_bal - r_amt_q;
          end
        end
        OP_PIN:  pin_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op_q        <= '0;
      r_acct_q      <= '0;
      r_pin_q       <= '0;
      r_npin_q      <= '0;
      r_dst_q       <= '0;
      r_amt_q       <= '0;
      src_hit_q     <= 1'b0;
      src_idx_q     <= '0;
      dst_hit_q     <= 1'b0;
      dst_idx_q     <= '0;
      rsp_status_q  <= '0;
      rsp_balance_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        tab_pin_q[i]  <= DEFAULT_PIN;
        tab_bal_q[i]  <= INIT_BALANCE;
        tab_fail_q[i] <= '0;
        tab_lock_q[i] <= 1'b0;
      end
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        r_op_q   <= req_op;
        r_acct_q <= req_account;
        r_pin_q  <= req_pin;
        r_npin_q <= req_new_pin;
        r_dst_q  <= req_dest_account;
        r_amt_q  <= req_amount;
      end
      if (state_q == S_LOOKUP) begin
        src_hit_q <= src_hit_d;
        src_idx_q <= src_idx_d;
        dst_hit_q <= dst_hit_d;
        dst_idx_q <= dst_idx_d;
      end
      if (state_q == S_EXEC) begin
        rsp_status_q  <= ex_status;
        rsp_balance_q <= ex_bal;
        if (src_we)   tab_bal_q[src_idx_q]  <= src_nx;
        if (dst_we)   tab_bal_q[dst_idx_q]  <= dst_nx;
        if (pin_we)   tab_pin_q[src_idx_q]  <= r_npin_q;
        if (fail_inc) tab_fail_q[src_idx_q] <= fail_nx;
        if (fail_clr) tab_fail_q[src_idx_q] <= '0;
        if (lock_set) tab_lock_q[src_idx_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// Scoreboard bench for atm_account_server: expected responses are queued
// at request accept and compared when the response is presented.
module tb_atm_account_server;

  localparam logic [2:0] OP_VER = 3'd0;
  localparam logic [2:0] OP_BAL = 3'd1;
  localparam logic [2:0] OP_DEP = 3'd2;
  localparam logic [2:0] OP_WDR = 3'd3;
  localparam logic [2:0] OP_XFR = 3'd4;
  localparam logic [2:0] OP_PIN = 3'd5;

  localparam logic [2:0] OK   = 3'd0;
  localparam logic [2:0] BPIN = 3'd1;
  localparam logic [2:0] NOAC = 3'd2;
  localparam logic [2:0] INSF = 3'd3;
  localparam logic [2:0] OVF  = 3'd4;
  localparam logic [2:0] LOCK = 3'd5;
  localparam logic [2:0] BOP  = 3'd6;
  localparam logic [2:0] NODS = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [16:0] req_account, req_pin, req_new_pin, req_dest_account;
  logic [18:0] req_amount;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_status;
  logic [18:0] rsp_balance;

  always #5 clk = ~clk;

  atm_account_server dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_account      (req_account),
    .req_pin          (req_pin),
    .req_new_pin      (req_new_pin),
    .req_dest_account (req_dest_account),
    .req_amount       (req_amount),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_status       (rsp_status),
    .rsp_balance      (rsp_balance)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [18:0] bal;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive(logic [2:0] op, logic [16:0] acct, logic [16:0] pin,
                       logic [16:0] npin, logic [16:0] dst,
                       logic [18:0] amt);
    req_op           = op;
    req_account      = acct;
    req_pin          = pin;
    req_new_pin      = npin;
    req_dest_account = dst;
    req_amount       = amt;
    req_valid        = 1'b1;
  endtask

  task automatic scramble();
    req_op           = 3'($urandom);
    req_account      = 17'($urandom);
    req_pin          = 17'($urandom);
    req_new_pin      = 17'($urandom);
    req_dest_account = 17'($urandom);
    req_amount       = 19'($urandom);
  endtask

  task automatic txn(string tag, logic [2:0] op, logic [16:0] acct,
                     logic [16:0] pin, logic [16:0] npin, logic [16:0] dst,
                     logic [18:0] amt, logic [2:0] est, logic [18:0] ebal,
                     int hold);
    int          lat;
    exp_t        e;
    logic [2:0]  s0;
    logic [18:0] b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(op, acct, pin, npin, dst, amt);
    lat = 0;
    while (!req_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!req_ready) begin
      check({tag, ".accept"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.st  = est;
    e.bal = ebal;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    check({tag, ".rdy_lo"}, req_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, 2);
    if (!rsp_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    s0 = rsp_status;
    b0 = rsp_balance;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold"},
            rsp_valid && !req_ready && rsp_status == s0 &&
            rsp_balance == b0, 1);
    end
    rsp_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".st"}, rsp_status, e.st);
      check({tag, ".bal"}, rsp_balance, e.bal);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rdy_hi"}, req_ready && !rsp_valid, 1);
  endtask

  task automatic abort_in_lookup();
    bit seen;
    @(negedge clk);
    drive(OP_PIN, 17'd1000, 17'd4321, 17'd777, 17'd0, 19'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort.no_rsp", seen, 0);
    check("abort.rdy", req_ready, 1);
  endtask

  initial begin
    scramble();
    do_reset();
    check("rst.rdy", req_ready, 1);
    check("rst.vld", rsp_valid, 0);
    check("rst.st", rsp_status, 0);
    check("rst.bal", rsp_balance, 0);

    txn("bal1000", OP_BAL, 17'd1000, 17'd1234, 0, 0, 0, OK, 19'd5000, 0);

    txn("wdr2000", OP_WDR, 17'd1001, 17'd1234, 0, 0, 19'd2000,
        OK, 19'd3000, 0);
    txn("wdr3001", OP_WDR, 17'd1001, 17'd1234, 0, 0, 19'd3001,
        INSF, 19'd3000, 0);
    txn("depovf", OP_DEP, 17'd1001, 17'd1234, 0, 0, 19'd524287,
        OVF, 19'd3000, 0);
    txn("dep0", OP_DEP, 17'd1001, 17'd1234, 0, 0, 19'd0, OK, 19'd3000, 0);

    txn("xfr", OP_XFR, 17'd1000, 17'd1234, 0, 17'd1002, 19'd1500,
        OK, 19'd3500, 0);
    txn("bal1002", OP_BAL, 17'd1002, 17'd1234, 0, 0, 0, OK, 19'd6500, 0);
    txn("xfrself", OP_XFR, 17'd1000, 17'd1234, 0, 17'd1000, 19'd10,
        NODS, 19'd3500, 0);
    txn("xfr9999", OP_XFR, 17'd1000, 17'd1234, 0, 17'd9999, 19'd10,
        NODS, 19'd3500, 0);
    txn("bal1000b", OP_BAL, 17'd1000, 17'd1234, 0, 0, 0, OK, 19'd3500, 0);
    txn("bal1002b", OP_BAL, 17'd1002, 17'd1234, 0, 0, 0, OK, 19'd6500, 0);

    txn("depmax", OP_DEP, 17'd1002, 17'd1234, 0, 0, 19'd517787,
        OK, 19'd524287, 0);
    txn("xfrovf", OP_XFR, 17'd1000, 17'd1234, 0, 17'd1002, 19'd1,
        OVF, 19'd3500, 0);
    txn("xfrinsf", OP_XFR, 17'd1000, 17'd1234, 0, 17'd1001, 19'd3501,
        INSF, 19'd3500, 0);
    txn("wdrall", OP_WDR, 17'd1001, 17'd1234, 0, 0, 19'd3000,
        OK, 19'd0, 0);
    txn("noacct", OP_BAL, 17'd1004, 17'd1234, 0, 0, 0, NOAC, 19'd0, 0);

    txn("clr.bad1", OP_VER, 17'd1001, 17'd1, 0, 0, 0, BPIN, 19'd0, 0);
    txn("clr.bad2", OP_WDR, 17'd1001, 17'd1, 0, 0, 19'd5, BPIN, 19'd0, 0);
    txn("clr.ok1", OP_VER, 17'd1001, 17'd1234, 0, 0, 0, OK, 19'd0, 0);
    txn("clr.bad3", OP_VER, 17'd1001, 17'd1, 0, 0, 0, BPIN, 19'd0, 0);
    txn("clr.bad4", OP_VER, 17'd1001, 17'd1, 0, 0, 0, BPIN, 19'd0, 0);
    txn("clr.ok2", OP_VER, 17'd1001, 17'd1234, 0, 0, 0, OK, 19'd0, 0);

    for (int i = 0; i < 3; i++)
      txn("lk.bad", OP_VER, 17'd1003, 17'd1111, 0, 0, 0, BPIN, 19'd0, 0);
    txn("lk.good", OP_BAL, 17'd1003, 17'd1234, 0, 0, 0, LOCK, 19'd0, 0);
    txn("lk.badp", OP_BAL, 17'd1003, 17'd1111, 0, 0, 0, LOCK, 19'd0, 0);

    do_reset();
    txn("rst.1003", OP_BAL, 17'd1003, 17'd1234, 0, 0, 0, OK, 19'd5000, 0);
    txn("rst.1000", OP_BAL, 17'd1000, 17'd1234, 0, 0, 0, OK, 19'd5000, 0);

    txn("pinchg", OP_PIN, 17'd1000, 17'd1234, 17'd4321, 0, 0,
        OK, 19'd5000, 5);
    txn("pin.old", OP_VER, 17'd1000, 17'd1234, 0, 0, 0, BPIN, 19'd0, 0);
    txn("pin.new", OP_BAL, 17'd1000, 17'd4321, 0, 0, 0, OK, 19'd5000, 0);
    txn("badop7", 3'd7, 17'd1000, 17'd4321, 0, 0, 0, BOP, 19'd0, 0);
    txn("badop6", 3'd6, 17'd9999, 17'd4321, 0, 0, 0, BOP, 19'd0, 0);

    abort_in_lookup();
    txn("abort.pin", OP_BAL, 17'd1000, 17'd1234, 0, 0, 0,
        OK, 19'd5000, 0);

    check("sb.drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
